input_port_vc: RTL and testbench

INPUT_PORT_VC -- requirements
Module: input_port_vc

---
 rtl/input_port_vc.sv | 137 +++++++++++++
 tb/tb_input_port_vc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_vc.sv
// Router input port: one circular flit FIFO per virtual channel, a per-VC
// IDLE/VA/ACTIVE controller, switch-grant pop and a registered crossbar output.
// Optional sticky drop flag: define INPUT_PORT_VC_ERR_FLAG_EN to add error_o.
module input_port_vc #(
  parameter int BUFFER_SIZE = 8,
  parameter int VC_NUM      = 2,
  parameter int VC_ID_W     = 4,
  parameter int PAYLOAD_W   = 8,
  localparam int FLIT_W     = 2 + VC_ID_W + PAYLOAD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              valid_i,
  output logic [VC_NUM-1:0] va_req_o,
  input  logic [VC_NUM-1:0] va_grant_i,
  output logic [VC_NUM-1:0] sa_req_o,
  input  logic [VC_NUM-1:0] sa_grant_i,
  output logic [FLIT_W-1:0] flit_o,
  output logic              valid_o,
`ifdef INPUT_PORT_VC_ERR_FLAG_EN
  output logic              error_o,
`endif
  output logic [VC_NUM-1:0] credit_o
);

  // Flit layout, MSB first: {flit_label[1:0], vc_id[VC_ID_W-1:0], payload}
  localparam logic [1:0] LBL_HEAD     = 2'd0;
  localparam logic [1:0] LBL_TAIL     = 2'd2;
  localparam logic [1:0] LBL_HEADTAIL = 2'd3;

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_e;

  logic [FLIT_W-1:0] mem     [VC_NUM][BUFFER_SIZE];
  logic [PTR_W-1:0]  wr_ptr  [VC_NUM];
  logic [PTR_W-1:0]  rd_ptr  [VC_NUM];
  logic [CNT_W-1:0]  count   [VC_NUM];
  logic [1:0]        head_label [VC_NUM];
  vc_state_e         state_q [VC_NUM];
  vc_state_e         state_d [VC_NUM];

  logic [VC_ID_W-1:0] in_vc;
  logic [VC_NUM-1:0]  served;
  logic [VC_NUM-1:0]  pop;
  logic [VC_NUM-1:0]  push;
  logic [FLIT_W-1:0]  pop_flit;
  logic               drop;

  assign in_vc = data_i[PAYLOAD_W +: VC_ID_W];

  // NOTE: every combinational output gets a default before the loops so no
  // path through the block leaves a variable unassigned (no latch inferred).
  always_comb begin
    va_req_o = '0;
    sa_req_o = '0;
    push     = '0;
    pop_flit = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      head_label[v] = mem[v][rd_ptr[v]][FLIT_W-1 -: 2];
      va_req_o[v]   = (state_q[v] == VA);
      sa_req_o[v]   = (state_q[v] == ACTIVE) && (count[v] != '0);
    end
    // Grants to non-requesting VCs are masked, then the lowest index wins.
    served = sa_grant_i & sa_req_o;
    pop    = served & (~served + VC_NUM'(1));
    for (int v = 0; v < VC_NUM; v++) begin
      if (pop[v]) pop_flit = mem[v][rd_ptr[v]];
      // A full FIFO still takes the flit when it is being popped this edge.
      push[v] = valid_i && (32'(in_vc) == v) &&
                ((count[v] != CNT_W'(BUFFER_SIZE)) || pop[v]);
    end
    drop = valid_i && (push == '0);
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      state_d[v] = state_q[v];
      case (state_q[v])
        IDLE:
          if ((count[v] != '0) &&
              ((head_label[v] == LBL_HEAD) || (head_label[v] == LBL_HEADTAIL)))
            state_d[v] = VA;
        VA:
          if (va_grant_i[v]) state_d[v] = ACTIVE;
        ACTIVE:
          if (pop[v] &&
              ((head_label[v] == LBL_TAIL) || (head_label[v] == LBL_HEADTAIL)))
            state_d[v] = IDLE;
        default: state_d[v] = IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v]  <= '0;
        rd_ptr[v]  <= '0;
        count[v]   <= '0;
        state_q[v] <= IDLE;
      end
      flit_o   <= '0;
      valid_o  <= 1'b0;
      credit_o <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= state_d[v];
        if (push[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        if (pop[v])  rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        count[v] <= count[v] + CNT_W'(push[v]) - CNT_W'(pop[v]);
      end
      valid_o  <= |pop;
      credit_o <= pop;
      if (|pop) flit_o <= pop_flit;
    end
  end

  // NOTE: the flit storage is deliberately not reset; occupancy counters
  // decide what is valid, so stale entries are never observed.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++)
      if (push[v]) mem[v][wr_ptr[v]] <= data_i;
  end

`ifdef INPUT_PORT_VC_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst)      error_o <= 1'b0;
    else if (drop) error_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_input_port_vc.sv
// Self-checking bench for input_port_vc: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_input_port_vc;

  localparam int BS        = 8;
  localparam int VC        = 2;
  localparam int VC_ID_W   = 4;
  localparam int PAYLOAD_W = 8;
  localparam int FLIT_W    = 2 + VC_ID_W + PAYLOAD_W;

  localparam logic [1:0] HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3;
  localparam int ST_IDLE = 0, ST_VA = 1, ST_ACT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] data_i;
  logic              valid_i;
  logic [VC-1:0]     va_req_o, va_grant_i, sa_req_o, sa_grant_i, credit_o;
  logic [FLIT_W-1:0] flit_o;
  logic              valid_o;
`ifdef INPUT_PORT_VC_ERR_FLAG_EN
  logic              error_o;
`endif

  input_port_vc #(.BUFFER_SIZE(BS), .VC_NUM(VC), .VC_ID_W(VC_ID_W),
                  .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .va_req_o(va_req_o), .va_grant_i(va_grant_i),
    .sa_req_o(sa_req_o), .sa_grant_i(sa_grant_i),
    .flit_o(flit_o), .valid_o(valid_o),
`ifdef INPUT_PORT_VC_ERR_FLAG_EN
    .error_o(error_o),
`endif
    .credit_o(credit_o));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one queue per VC plus a packet phase per VC.
  logic [FLIT_W-1:0] mq [VC][$];
  int                mst [VC];
  logic              exp_valid, exp_err;
  logic [VC-1:0]     exp_credit;
  logic [FLIT_W-1:0] exp_flit;
  logic [FLIT_W-1:0] out_q [$];

  typedef struct {
    logic [FLIT_W-1:0] din;
    logic              vin;
    logic [VC-1:0]     vag, sag;
    logic [VC-1:0]     va, sa;
    logic              vo;
    logic [VC-1:0]     cr;
    logic [FLIT_W-1:0] fo;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] lbl, input int vc,
                                           input int pl);
    return {lbl, VC_ID_W'(vc), PAYLOAD_W'(pl)};
  endfunction

  function automatic logic [1:0] lbl_of(input logic [FLIT_W-1:0] f);
    return f[FLIT_W-1 -: 2];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [FLIT_W-1:0] d, input logic v,
                            input logic [VC-1:0] vag, input logic [VC-1:0] sag);
    int sel;
    int nst [VC];
    int tvc;
    logic [FLIT_W-1:0] f;
    if (!r) begin
      for (int c = 0; c < VC; c++) begin
        mq[c].delete();
        mst[c] = ST_IDLE;
      end
      exp_valid = 1'b0; exp_credit = '0; exp_flit = '0; exp_err = 1'b0;
      return;
    end
    sel = -1;
    for (int c = 0; c < VC; c++)
      if (sel < 0 && sag[c] && mst[c] == ST_ACT && mq[c].size() > 0) sel = c;
    for (int c = 0; c < VC; c++) begin
      nst[c] = mst[c];
      if (mst[c] == ST_IDLE && mq[c].size() > 0 &&
          (lbl_of(mq[c][0]) == HEAD || lbl_of(mq[c][0]) == HEADTAIL))
        nst[c] = ST_VA;
      else if (mst[c] == ST_VA && vag[c])
        nst[c] = ST_ACT;
      else if (mst[c] == ST_ACT && sel == c &&
               (lbl_of(mq[c][0]) == TAIL || lbl_of(mq[c][0]) == HEADTAIL))
        nst[c] = ST_IDLE;
    end
    exp_valid = 1'b0;
    exp_credit = '0;
    if (sel >= 0) begin
      f = mq[sel].pop_front();
      exp_valid = 1'b1;
      exp_credit[sel] = 1'b1;
      exp_flit = f;
    end
    if (v) begin
      tvc = int'(d[PAYLOAD_W +: VC_ID_W]);
      if (tvc < VC && mq[tvc].size() < BS) mq[tvc].push_back(d);
      else exp_err = 1'b1;
    end
    for (int c = 0; c < VC; c++) mst[c] = nst[c];
  endtask

  // One clock: drive, check requests, step model, check registered outputs.
  task automatic cycle(input logic r, input logic [FLIT_W-1:0] d, input logic v,
                       input logic [VC-1:0] vag, input logic [VC-1:0] sag);
    logic [VC-1:0] eva, esa;
    rst = r; data_i = d; valid_i = v; va_grant_i = vag; sa_grant_i = sag;
    #1;
    for (int c = 0; c < VC; c++) begin
      eva[c] = (mst[c] == ST_VA);
      esa[c] = (mst[c] == ST_ACT) && (mq[c].size() > 0);
    end
    check("va_req_o", 32'(va_req_o), 32'(eva));
    check("sa_req_o", 32'(sa_req_o), 32'(esa));
    model_step(r, d, v, vag, sag);
    @(posedge clk);
    #1;
    check("valid_o", 32'(valid_o), 32'(exp_valid));
    check("credit_o", 32'(credit_o), 32'(exp_credit));
    check("flit_o", 32'(flit_o), 32'(exp_flit));
`ifdef INPUT_PORT_VC_ERR_FLAG_EN
    check("error_o", 32'(error_o), 32'(exp_err));
`endif
    if (valid_o === 1'b1) out_q.push_back(flit_o);
  endtask

  task automatic idle(input int n, input logic [VC-1:0] vag, input logic [VC-1:0] sag);
    for (int i = 0; i < n; i++) cycle(1'b1, '0, 1'b0, vag, sag);
  endtask

  initial begin
    // Reset with random inputs on the pins for two edges.
    rst = 1'b0;
    repeat (2) begin
      data_i = FLIT_W'($urandom); valid_i = 1'($urandom);
      va_grant_i = VC'($urandom); sa_grant_i = VC'($urandom);
      @(posedge clk);
    end
    #1;
    model_step(1'b0, '0, 1'b0, '0, '0);
    check("rst va_req_o", 32'(va_req_o), 0);
    check("rst sa_req_o", 32'(sa_req_o), 0);
    check("rst valid_o", 32'(valid_o), 0);
    check("rst credit_o", 32'(credit_o), 0);
    check("rst flit_o", 32'(flit_o), 0);
`ifdef INPUT_PORT_VC_ERR_FLAG_EN
    check("rst error_o", 32'(error_o), 0);
`endif

    // Single HEAD/BODY/TAIL packet on VC0, outputs sampled after each edge.
    tbl[0] = '{mk(HEAD,0,8'h11), 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, '0};
    tbl[1] = '{mk(BODY,0,8'h22), 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, '0};
    tbl[2] = '{mk(TAIL,0,8'h33), 1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, '0};
    tbl[3] = '{'0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 1'b1, 2'b01, mk(HEAD,0,8'h11)};
    tbl[4] = '{'0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 1'b1, 2'b01, mk(BODY,0,8'h22)};
    tbl[5] = '{'0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, mk(TAIL,0,8'h33)};
    tbl[6] = '{'0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, mk(TAIL,0,8'h33)};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, tbl[i].din, tbl[i].vin, tbl[i].vag, tbl[i].sag);
      check($sformatf("tbl%0d va", i), 32'(va_req_o), 32'(tbl[i].va));
      check($sformatf("tbl%0d sa", i), 32'(sa_req_o), 32'(tbl[i].sa));
      check($sformatf("tbl%0d valid", i), 32'(valid_o), 32'(tbl[i].vo));
      check($sformatf("tbl%0d credit", i), 32'(credit_o), 32'(tbl[i].cr));
      check($sformatf("tbl%0d flit", i), 32'(flit_o), 32'(tbl[i].fo));
    end

    // Overflow: nine flits into VC1 with no grants; the ninth is dropped.
    cycle(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 9; i++)
      cycle(1'b1, mk(i == 0 ? HEAD : BODY, 1, i), 1'b1, 2'b00, 2'b00);
`ifdef INPUT_PORT_VC_ERR_FLAG_EN
    check("overflow error_o", 32'(error_o), 1);
`endif
    out_q.delete();
    idle(14, 2'b10, 2'b10);
    check("overflow count", out_q.size(), 8);
    if (out_q.size() == 8) check("overflow last", 32'(out_q[7][PAYLOAD_W-1:0]), 7);

    // Full FIFO with push and pop on the same edge keeps the pushed flit.
    cycle(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, mk(i == 0 ? HEAD : BODY, 0, i), 1'b1, 2'b01, 2'b00);
    check("full sa_req", 32'(sa_req_o), 32'(2'b01));
    out_q.delete();
    cycle(1'b1, mk(TAIL, 0, 8'hAA), 1'b1, 2'b00, 2'b01);
    check("full+pop sa_req", 32'(sa_req_o), 32'(2'b01));
    idle(12, 2'b00, 2'b01);
    check("full+pop count", out_q.size(), 9);
    if (out_q.size() == 9) check("full+pop last", 32'(out_q[8][PAYLOAD_W-1:0]), 32'h00AA);

    // Interleave: both VCs request together, lowest index served first.
    cycle(1'b0, '0, 1'b0, '0, '0);
    cycle(1'b1, mk(HEADTAIL, 0, 8'h50), 1'b1, 2'b11, 2'b00);
    cycle(1'b1, mk(HEADTAIL, 1, 8'h51), 1'b1, 2'b11, 2'b00);
    idle(3, 2'b11, 2'b00);
    check("ilv both req", 32'(sa_req_o), 32'(2'b11));
    out_q.delete();
    idle(4, 2'b00, 2'b11);
    check("ilv count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      check("ilv first vc", 32'(out_q[0][PAYLOAD_W +: VC_ID_W]), 0);
      check("ilv second vc", 32'(out_q[1][PAYLOAD_W +: VC_ID_W]), 1);
    end

    // Wrap: twenty single-flit packets stream through VC0.
    cycle(1'b0, '0, 1'b0, '0, '0);
    out_q.delete();
    for (int i = 0; i < 80; i++)
      cycle(1'b1, mk(HEADTAIL, 0, i / 4), (i % 4) == 0, 2'b01, 2'b01);
    idle(20, 2'b01, 2'b01);
    check("wrap count", out_q.size(), 20);
    for (int i = 0; i < 20 && i < out_q.size(); i++)
      check($sformatf("wrap order %0d", i), 32'(out_q[i][PAYLOAD_W-1:0]), i);

    // Random traffic, including illegal vc_id and occasional mid-packet reset.
    cycle(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
            mk(2'($urandom), $urandom_range(0, 3), $urandom_range(0, 255)),
            1'($urandom), VC'($urandom), VC'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
